// File: rtl/mem_lsu_if.sv
// Core-side request/response bundle and RAM-side bus of the load/store unit.
// slave is the LSU's view; master is the core plus RAM environment.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_r_en;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [1:0]  mem_state;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
    input  mem_r_data, mem_state
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
    output mem_r_data, mem_state
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word core requests into aligned word RAM
// accesses, using read-modify-write for sub-word stores.
module mem_lsu #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter              NAME     = ""
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mem_lsu_if.slave   io_bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RCHK = 3'd2,
    S_WR   = 3'd3,
    S_WCHK = 3'd4,
    S_RESP = 3'd5
  } state_t;

  if (NAME != "") begin : g_named
  end

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_err;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic [31:0] r_mem_w_data;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_word_addr;
  logic [31:0] r_wdata;

  state_t      w_state_nxt;
  logic [31:0] w_rdata_nxt;
  logic [1:0]  w_err_nxt;
  logic [31:0] w_wdata_nxt;
  logic [31:0] w_off;
  logic        w_accept;

  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] data, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (size)
      2'b00:   res = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = data;
    endcase
    return res;
  endfunction

  // Little-endian lane merge of right-justified store data into the read word.
  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          2'd3:    res[31:24] = wd[7:0];
          default: res = old;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  assign w_off    = io_bus.req_addr - MEM_BASE;
  assign w_accept = io_bus.req_valid && r_req_ready;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_resp_rdata;
    w_err_nxt   = r_resp_err;
    w_wdata_nxt = r_mem_w_data;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) begin
          if (f_misaligned(io_bus.req_size, w_off[1:0])) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 2'b11;
            w_rdata_nxt = 32'h0000_0000;
          end else if (io_bus.req_we && (io_bus.req_size == 2'b10)) begin
            w_state_nxt = S_WR;
            w_wdata_nxt = io_bus.req_wdata;
          end else begin
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: w_state_nxt = S_RCHK;
      S_RCHK: begin
        if (io_bus.mem_state != 2'b00) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = io_bus.mem_state;
          w_rdata_nxt = 32'h0000_0000;
        end else if (!r_we) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 2'b00;
          w_rdata_nxt = f_extract(io_bus.mem_r_data, r_size, r_lane, r_unsigned);
        end else begin
          w_state_nxt = S_WR;
          w_wdata_nxt = f_merge(io_bus.mem_r_data, r_wdata, r_size, r_lane);
        end
      end
      S_WR: w_state_nxt = S_WCHK;
      S_WCHK: begin
        w_state_nxt = S_RESP;
        w_err_nxt   = io_bus.mem_state;
        w_rdata_nxt = 32'h0000_0000;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, registered outputs and captured request fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 2'b00;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_w_data <= 32'h0000_0000;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_word_addr  <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_mem_r_en   <= (w_state_nxt == S_RD);
      r_mem_w_en   <= (w_state_nxt == S_WR);
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_err_nxt;
      r_mem_w_data <= w_wdata_nxt;
      if (w_accept) begin
        r_we        <= io_bus.req_we;
        r_size      <= io_bus.req_size;
        r_unsigned  <= io_bus.req_unsigned;
        r_lane      <= w_off[1:0];
        r_word_addr <= {w_off[31:2], 2'b00};
        r_wdata     <= io_bus.req_wdata;
      end
    end
  end

  assign io_bus.req_ready  = r_req_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_rdata = r_resp_rdata;
  assign io_bus.resp_err   = r_resp_err;
  assign io_bus.mem_r_en   = r_mem_r_en;
  assign io_bus.mem_r_addr = r_word_addr;
  assign io_bus.mem_w_en   = r_mem_w_en;
  assign io_bus.mem_w_addr = r_word_addr;
  assign io_bus.mem_w_data = r_mem_w_data;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu against a 1024-word RAM model (bytes 0x0000-0x0FFF).
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if bus();

  mem_lsu #(.MEM_BASE(32'h0000_0000), .NAME("u_dut")) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  logic [31:0] ram [0:1023];
  bit          init_done = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  bit          both_seen = 1'b0;
  bit          addr_bad = 1'b0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  // RAM model: one-cycle read data and status, out-of-range reports 10.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[4]         <= 32'h8899_AABB;
      bus.mem_r_data <= 32'h0;
      bus.mem_state  <= 2'b00;
      init_done      <= 1'b1;
    end else begin
      if ((bus.mem_r_en && bus.mem_r_addr[1:0] != 2'b00) ||
          (bus.mem_w_en && bus.mem_w_addr[1:0] != 2'b00)) addr_bad <= 1'b1;
      if (bus.mem_r_en && bus.mem_w_en) begin
        both_seen     <= 1'b1;
        bus.mem_state <= 2'b01;
      end else if (bus.mem_r_en) begin
        rd_cnt <= rd_cnt + 1;
        if (bus.mem_r_addr < 32'h1000) begin
          bus.mem_r_data <= ram[bus.mem_r_addr[11:2]];
          bus.mem_state  <= 2'b00;
        end else begin
          bus.mem_r_data <= 32'h0;
          bus.mem_state  <= 2'b10;
        end
      end else if (bus.mem_w_en) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= bus.mem_w_addr;
        last_wdata <= bus.mem_w_data;
        if (bus.mem_w_addr < 32'h1000) begin
          ram[bus.mem_w_addr[11:2]] <= bus.mem_w_data;
          bus.mem_state <= 2'b00;
        end else begin
          bus.mem_state <= 2'b10;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] err, output int lat);
    int w;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_before_accept", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [21];

  initial begin
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          rd0, wr0, w;
    bit          resp_seen;

    //            we    size   uns   addr         wdata         rdata         err   lat rd wr wdata
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'hFFFF_FFAA, 2'b00, 3, 1, 0, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h0000_0088, 2'b00, 3, 1, 0, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'h0000_8899, 2'b00, 3, 1, 0, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'hFFFF_AABB, 2'b00, 3, 1, 0, 32'h0};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,        32'h8899_AABB, 2'b00, 3, 1, 0, 32'h0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_1234, 32'h0,        2'b00, 5, 1, 1, 32'h1234_AABB};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h1234_AABB, 2'b00, 3, 1, 0, 32'h0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0077, 32'h0,        2'b00, 5, 1, 1, 32'h1234_77BB};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0077, 2'b00, 3, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        32'h0,         2'b11, 1, 0, 0, 32'h0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         2'b11, 1, 0, 0, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0,         2'b11, 1, 0, 0, 32'h0};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_5555, 32'h0,        2'b11, 1, 0, 0, 32'h0};
    vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'h0000_00EE, 32'h0,        2'b10, 3, 1, 0, 32'h0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        2'b00, 3, 0, 1, 32'hDEAD_BEEF};
    vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_AB5A, 32'h0,        2'b00, 5, 1, 1, 32'h5AAD_BEEF};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        32'h0000_005A, 2'b00, 3, 1, 0, 32'h0};
    vecs[17] = '{1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,        32'hFFFF_FFAD, 2'b00, 3, 1, 0, 32'h0};
    vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        32'h0000_5AAD, 2'b00, 3, 1, 0, 32'h0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'h0,         2'b10, 3, 1, 0, 32'h0};
    vecs[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'h0BAD_0BAD, 32'h0,        2'b10, 3, 0, 1, 32'h0BAD_0BAD};

    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_mem_r_en",   {31'h0, bus.mem_r_en},   32'h0);
    check("rst_mem_w_en",   {31'h0, bus.mem_w_en},   32'h0);
    check("rst_resp_rdata", bus.resp_rdata,          32'h0);
    check("rst_resp_err",   {30'h0, bus.resp_err},   32'h0);
    check("rst_mem_w_data", bus.mem_w_data,          32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {30'h0, err}, {30'h0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_reads", i), rd_cnt - rd0, vecs[i].exp_rd);
      check($sformatf("v%0d_writes", i), wr_cnt - wr0, vecs[i].exp_wr);
      if (vecs[i].exp_wr != 0) begin
        check($sformatf("v%0d_waddr", i), last_waddr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_resp_pulse", i), {31'h0, bus.resp_valid}, 32'h0);
      check($sformatf("v%0d_ready_after", i), {31'h0, bus.req_ready}, 32'h1);
      check($sformatf("v%0d_rdata_hold", i), bus.resp_rdata, vecs[i].exp_rdata);
    end

    // Reset while the RMW write is on the bus abandons the request.
    wr0 = wr_cnt;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0020;
    bus.req_wdata    = 32'h0000_0011;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    w = 0;
    while (!bus.mem_w_en && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("rmw_reached_wr", {31'h0, bus.mem_w_en}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_drops_w_en", {31'h0, bus.mem_w_en}, 32'h0);
    check("rst_ready_async", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) resp_seen = 1'b1;
    end
    check("no_resp_after_rst", {31'h0, resp_seen}, 32'h0);
    check("ready_after_rst", {31'h0, bus.req_ready}, 32'h1);
    check("no_write_after_rst", wr_cnt - wr0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, rdata, err, lat);
    check("post_rst_lw_rdata", rdata, 32'h5AAD_BEEF);
    check("post_rst_lw_err", {30'h0, err}, 32'h0);

    check("never_r_and_w", {31'h0, both_seen}, 32'h0);
    check("addr_low_bits", {31'h0, addr_bad}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit that sits directly upstream of the word-only block RAM.
- Accepts byte, halfword and word load/store requests from the core and converts them into aligned 32-bit RAM accesses.
- Sub-word stores use read-modify-write; sub-word loads are lane-extracted and sign- or zero-extended.
- RAM error codes are forwarded to the core, and misaligned requests are rejected before any RAM access.

Parameters:
- MEM_BASE, 32'h0000_0000, byte address of RAM word 0; subtracted from req_addr before forwarding.
- NAME, "", instance tag for simulation messages only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and on error.
- resp_err  out  2  00 ok, 01 r/w conflict, 10 out of bounds, 11 alignment or illegal size.
- mem_r_en  out  1  RAM read enable.
- mem_r_addr  out  32  RAM read address, bits [1:0] always 00.
- mem_r_data  in  32  RAM read data, valid the cycle after mem_r_en.
- mem_w_en  out  1  RAM write enable.
- mem_w_addr  out  32  RAM write address, bits [1:0] always 00.
- mem_w_data  out  32  RAM write data.
- mem_state  in  2  RAM status, valid the cycle after an enable.

Behaviour:
- Reset (async): state to IDLE. All outputs 0 except req_ready=1. Captured request registers cleared.
- Reset mid-operation abandons the request: no response is produced, and enables drop immediately. A RAM write already sampled on a prior edge is not undone.
- Accept: on a rising edge with req_valid && req_ready, capture we/size/unsigned/addr/wdata. Compute off = req_addr - MEM_BASE and word address {off[31:2],2'b00}. Lane = off[1:0].
- Alignment check at accept:
  - size 11 → error.
  - half with off[0]=1 → error.
  - word with off[1:0]≠00 → error.
  - On error go to RESP with err=11. No RAM enable is ever raised.
- States (mem_r_en and mem_w_en are never high together):
  - IDLE: req_ready=1.
    - Load or sub-word store → RD.
    - Word store → WR.
  - RD: mem_r_en=1 for exactly one cycle → RCHK.
  - RCHK: sample mem_state and mem_r_data.
    - mem_state≠00 → RESP, err=mem_state, rdata=0, no write.
    - Load → RESP with the extracted value.
    - Sub-word store → merge into the read word (byte: lane off[1:0]; half: lanes off[1]*2 and +1; little-endian), then WR.
  - WR: mem_w_en=1 for one cycle with the merged or full data → WCHK.
  - WCHK: sample mem_state; err=mem_state → RESP.
  - RESP: resp_valid=1 for one cycle, resp_rdata/resp_err valid → IDLE.
- Outside RESP, resp_rdata and resp_err hold their last values; resp_valid=0.
- Load extraction:
  - byte = rdata[8*lane+7:8*lane].
  - half = rdata[16*off[1]+15:16*off[1]].
  - Extend to 32 bits per req_unsigned.
  - Word loads ignore req_unsigned.
- Latency from the accept edge to resp_valid high:
  - load: 3 cycles.
  - word store: 3 cycles.
  - sub-word store: 5 cycles.
  - rejected request: 1 cycle.
  - RMW read error: 3 cycles.
- Throughput: one request in flight. req_ready=0 from the accept edge until RESP is exited; the next accept is possible the cycle after RESP.
- No response back-pressure: the core must take resp_valid when pulsed.
- mem_state is sampled only in RCHK/WCHK. Stale values at other times are ignored.
- Address wrap: off is computed modulo 2^32. Addresses below MEM_BASE wrap high and are reported by the RAM as out of bounds (10).

Test Plan:
- RAM word 0x10 = 0x8899AABB, MEM_BASE=0. LB 0x11, signed → resp_rdata 0xFFFFFFAA, err 00, 3 cycles after accept, exactly one mem_r_en pulse.
- LBU 0x13 → 0x00000088. LHU 0x12 → 0x00008899. LH 0x10 → 0xFFFFAABB.
- SH 0x12, wdata 0x00001234 → one read then one write of 0x1234AABB to 0x10, 5 cycles. A follow-up LW 0x10 returns 0x1234AABB.
- LW 0x06, and size 11 at 0x10 → resp_err 11 one cycle after accept; mem_r_en/mem_w_en never asserted; resp_rdata 0.
- 1024-word RAM, SB 0x1000 → read returns state 10; resp_err 10 at 3 cycles; mem_w_en never asserted.
- SB 0x20 with rst pulsed during WR → no resp_valid; req_ready=1 after reset. Back-to-back LW/SW stream never shows mem_r_en && mem_w_en.
